// File: rtl/bitmap_allocator_if.sv
// Request/response bundle between a client and the bitmap allocator.
// The client drives allocation, release and error-clear requests; the
// allocator returns grant pulses, the next candidate index and pool status.
interface bitmap_allocator_if #(
    parameter int LIST_SIZE = 32
);
    localparam int IW = $clog2(LIST_SIZE);

    logic          ALLOC_REQ;
    logic          ALLOC_GNT;
    logic          ALLOC_FAIL;
    logic [IW-1:0] ALLOC_IDX;
    logic          FREE_REQ;
    logic [IW-1:0] FREE_IDX;
    logic [IW-1:0] AVAILABLE;
    logic          VALID;
    logic [IW:0]   FREE_COUNT;
    logic          FULL;
    logic          EMPTY;
    logic          ERR;
    logic          ERR_CLR;

    modport master (
        output ALLOC_REQ, FREE_REQ, FREE_IDX, ERR_CLR,
        input  ALLOC_GNT, ALLOC_FAIL, ALLOC_IDX, AVAILABLE, VALID,
               FREE_COUNT, FULL, EMPTY, ERR
    );

    modport slave (
        input  ALLOC_REQ, FREE_REQ, FREE_IDX, ERR_CLR,
        output ALLOC_GNT, ALLOC_FAIL, ALLOC_IDX, AVAILABLE, VALID,
               FREE_COUNT, FULL, EMPTY, ERR
    );
endinterface

// File: rtl/bitmap_allocator.sv
// Bitmap entry allocator: tracks LIST_SIZE entries in an occupancy vector
// (1 = allocated) with a registered free counter. The next grant candidate
// is the lowest free index, or with ROUND_ROBIN the first free index at or
// after a rotating pointer. Grants land one cycle after the request; the
// candidate search always looks at the pre-edge vector, so an entry being
// released this cycle is never handed out in the same cycle.
module bitmap_allocator #(
    parameter int LIST_SIZE   = 32,
    parameter int ROUND_ROBIN = 0
) (
    input  logic              CLK,
    input  logic              RSTN,
    bitmap_allocator_if.slave bus
);
    localparam int              IW       = $clog2(LIST_SIZE);
    localparam logic [IW:0]     FULL_CNT = (IW+1)'(LIST_SIZE);
    localparam logic [IW-1:0]   LAST_IDX = IW'(LIST_SIZE - 1);

    logic [LIST_SIZE-1:0] occ_q;
    logic [LIST_SIZE-1:0] occ_d;
    logic [IW:0]          cnt_q;
    logic [IW:0]          cnt_d;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        ptr_d;
    logic [IW-1:0]        avail;
    logic                 found;
    logic                 alloc_ok;
    logic                 free_in_range;
    logic                 free_ok;
    logic                 free_bad;
    logic                 gnt_p1;
    logic                 fail_p1;
    logic [IW-1:0]        idx_p1;
    logic                 err_q;

    // Candidate search: scan offsets high to low so the smallest offset wins
    always_comb begin : search
        int j;
        avail = '0;
        found = 1'b0;
        j     = 0;
        for (int i = LIST_SIZE - 1; i >= 0; i--) begin
            j = (ROUND_ROBIN != 0) ? int'(ptr_q) + i : i;
            if (j >= LIST_SIZE) begin
                j = j - LIST_SIZE;
            end
            if (!occ_q[j[IW-1:0]]) begin
                avail = j[IW-1:0];
                found = 1'b1;
            end
        end
    end

    // Request qualification and next occupancy/counter/pointer
    always_comb begin
        free_in_range = ({1'b0, bus.FREE_IDX} < FULL_CNT);
        free_ok       = bus.FREE_REQ && free_in_range && occ_q[bus.FREE_IDX];
        free_bad      = bus.FREE_REQ && !free_ok;
        alloc_ok      = bus.ALLOC_REQ && found;

        occ_d = occ_q;
        if (alloc_ok) begin
            occ_d[avail] = 1'b1;
        end
        if (free_ok) begin
            occ_d[bus.FREE_IDX] = 1'b0;
        end

        cnt_d = cnt_q + (IW+1)'(free_ok) - (IW+1)'(alloc_ok);

        ptr_d = ptr_q;
        if (alloc_ok) begin
            // wrap at LIST_SIZE, which need not be a power of two
            ptr_d = (avail == LAST_IDX) ? '0 : avail + IW'(1);
        end
    end

    // Occupancy vector, free counter and rotation pointer
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            occ_q <= '0;
            cnt_q <= FULL_CNT;
            ptr_q <= '0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

    // Stage p1: grant/fail pulses and the held grant index
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            gnt_p1  <= 1'b0;
            fail_p1 <= 1'b0;
            idx_p1  <= '0;
        end else begin
            gnt_p1  <= alloc_ok;
            fail_p1 <= bus.ALLOC_REQ && !found;
            if (alloc_ok) begin
                idx_p1 <= avail;
            end
        end
    end

    // Sticky error flag; a new bad release outranks a clear in the same cycle
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            err_q <= 1'b0;
        end else if (free_bad) begin
            err_q <= 1'b1;
        end else if (bus.ERR_CLR) begin
            err_q <= 1'b0;
        end
    end

    assign bus.ALLOC_GNT  = gnt_p1;
    assign bus.ALLOC_FAIL = fail_p1;
    assign bus.ALLOC_IDX  = idx_p1;
    assign bus.AVAILABLE  = avail;
    assign bus.VALID      = found;
    assign bus.FREE_COUNT = cnt_q;
    assign bus.FULL       = (cnt_q == '0);
    assign bus.EMPTY      = (cnt_q == FULL_CNT);
    assign bus.ERR        = err_q;

endmodule

// File: doc/bitmap_allocator.md
BITMAP_ALLOCATOR -- requirements
Module: bitmap_allocator

Interface
REQ-001 SHALL have parameter LIST_SIZE, default 32, number of tracked entries (any integer 2..1024; need not be a power of two).
REQ-002 SHALL have parameter ROUND_ROBIN, default 0; 0 = lowest-index-first search, 1 = rotating search.
REQ-003 SHALL define IW = $clog2(LIST_SIZE) for index widths.
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RSTN  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ALLOC_REQ  input  1  request one free entry this cycle.
REQ-007 SHALL have port ALLOC_GNT  output  1  registered one-cycle pulse, allocation succeeded.
REQ-008 SHALL have port ALLOC_FAIL  output  1  registered one-cycle pulse, request made while full.
REQ-009 SHALL have port ALLOC_IDX  output  IW  index granted; held until the next grant.
REQ-010 SHALL have port FREE_REQ  input  1  release entry FREE_IDX this cycle.
REQ-011 SHALL have port FREE_IDX  input  IW  index to release.
REQ-012 SHALL have port AVAILABLE  output  IW  combinational next-grant candidate.
REQ-013 SHALL have port VALID  output  1  at least one entry free (AVAILABLE meaningful).
REQ-014 SHALL have port FREE_COUNT  output  IW+1  number of free entries.
REQ-015 SHALL have ports FULL and EMPTY  output  1 each  FREE_COUNT==0 and FREE_COUNT==LIST_SIZE.
REQ-016 SHALL have port ERR  output  1  sticky error: double free or out-of-range free.
REQ-017 SHALL have port ERR_CLR  input  1  clears ERR.

Function
REQ-018 SHALL hold a LIST_SIZE-bit occupancy vector, bit=1 allocated, plus a registered IW+1-bit free counter.
REQ-019 ROUND_ROBIN=0: AVAILABLE SHALL be the lowest index with bit 0.
REQ-020 ROUND_ROBIN=1: AVAILABLE SHALL be the first free index at or above pointer PTR, wrapping LIST_SIZE-1 -> 0.
REQ-021 When VALID=0, AVAILABLE SHALL be 0.
REQ-022 ALLOC_REQ=1 with VALID=1 at edge N: bit AVAILABLE set, counter decremented, ALLOC_GNT=1 and ALLOC_IDX=AVAILABLE(N) in cycle N+1 (latency 1).
REQ-023 ROUND_ROBIN=1: on each grant PTR SHALL become (granted index+1) mod LIST_SIZE, wrapping at LIST_SIZE not 2^IW.
REQ-024 ALLOC_REQ=1 with VALID=0: no state change except ALLOC_FAIL=1 next cycle; request not queued.
REQ-025 ALLOC_GNT and ALLOC_FAIL SHALL be 0 in any cycle not following an ALLOC_REQ; back-to-back requests SHALL each be served, one per cycle.
REQ-026 FREE_REQ=1 with FREE_IDX<LIST_SIZE and bit set: bit cleared and counter incremented at the edge.
REQ-027 FREE_REQ=1 with bit already clear or FREE_IDX>=LIST_SIZE: occupancy and counter unchanged, ERR set at the edge.
REQ-028 Simultaneous valid alloc and free: both SHALL take effect; counter net unchanged; freed entry SHALL NOT be granted in the same cycle (search uses pre-edge vector).
REQ-029 ERR_CLR=1 clears ERR; a new error in the same cycle SHALL win (ERR stays 1).
REQ-030 FREE_COUNT SHALL never exceed LIST_SIZE nor underflow 0 under any input sequence.

Reset
REQ-031 RSTN=1 SHALL immediately and asynchronously clear occupancy, set counter=LIST_SIZE, PTR=0, ALLOC_GNT=0, ALLOC_FAIL=0, ALLOC_IDX=0, ERR=0.
REQ-032 During and after reset: AVAILABLE=0, VALID=1, EMPTY=1, FULL=0; requests during reset SHALL be ignored; reset mid-sequence discards all allocations.

Verification
REQ-033 LIST_SIZE=4, RR=0: 4 consecutive ALLOC_REQ -> GNT with IDX 0,1,2,3; FULL=1, FREE_COUNT=0; 5th request -> ALLOC_FAIL=1, GNT=0.
REQ-034 RR=0 after REQ-033: free 2 then alloc -> IDX=2; free 1 and alloc same cycle -> IDX=... none (full) then FAIL; next alloc -> IDX=1.
REQ-035 LIST_SIZE=5, RR=1: alloc x3 (0,1,2), free 0, alloc -> IDX=3, alloc -> IDX=4, alloc -> IDX=0 (wrap at 5).
REQ-036 Free of unallocated index 3 -> ERR=1, FREE_COUNT unchanged; ERR_CLR with concurrent bad free -> ERR stays 1; ERR_CLR alone -> ERR=0.
REQ-037 LIST_SIZE=5: FREE_IDX=7 -> ERR=1, no state change.
REQ-038 Assert RSTN asynchronously mid-burst (between edges) -> outputs reach reset values before next edge; after release first alloc -> IDX=0.
